// File: rtl/vga_tile_reader.sv
// vga_tile_reader: 640x480@60 tile-map video read engine with RGB332 output and aligned syncs.
// Latency: rgb/hsync/vsync/blank are registered one pixel after the counter value; each tile fetch takes 3 CLK.
// No backpressure: this is a read-only master, and both memories answer on the CLK after each address.
// Optional feature macro: TILE_INVERT_EN (tile bit 17 inverts that tile's glyph row).
module vga_tile_reader #(
  parameter int unsigned TILE_COLS = 40,
  parameter int unsigned TILE_ROWS = 30,
  parameter logic [7:0]  BG_COLOUR = 8'h00
) (
  input  logic        CLK,
  input  logic        CLR,
  output logic [11:0] vid_addr,
  input  logic [17:0] vid_data,
  output logic [9:0]  glyph_addr,
  input  logic [17:0] glyph_data,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb,
  output logic        blank,
  output logic        frame_start
);

  localparam logic [9:0] H_ACTIVE = 10'(TILE_COLS * 16);
  localparam logic [9:0] V_ACTIVE = 10'(TILE_ROWS * 16);
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  // Lookahead of 4 pixels: h values from 796 up wrap onto the start of the next line.
  localparam logic [9:0] H_WRAP_F = 10'd796;

  typedef enum logic [1:0] {S_IDLE, S_ADDR_T, S_ADDR_G, S_CAP} state_t;

  logic        r_pix_en;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  state_t      r_state;
  logic [11:0] r_vid_addr;
  logic [9:0]  r_glyph_addr;
  logic [3:0]  r_line_lo;
  logic [7:0]  r_tile_fg;
  logic [15:0] r_pend_pat;
  logic [7:0]  r_pend_col;
  logic [15:0] r_shift;
  logic [7:0]  r_fg;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic [7:0]  r_rgb;
`ifdef TILE_INVERT_EN
  logic        r_tile_inv;
`endif

  logic [9:0]  w_fetch_x;
  logic [9:0]  w_line;
  logic        w_fetch_slot;
  logic [4:0]  w_row;
  logic [5:0]  w_col;
  logic [11:0] w_tile_addr;
  logic        w_active;
  logic        w_load;
  logic [15:0] w_pat;
  logic [7:0]  w_fg;
  logic        w_unused;

  // Fetch lookahead position, target line and tile address (row*40 as two shifts).
  always_comb begin
    w_fetch_x    = (r_h_cnt >= H_WRAP_F) ? (r_h_cnt - H_WRAP_F) : (r_h_cnt + 10'd4);
    w_line       = r_v_cnt;
    if (r_h_cnt >= H_WRAP_F) begin
      w_line = (r_v_cnt == V_LAST) ? 10'd0 : (r_v_cnt + 10'd1);
    end
    w_fetch_slot = (w_fetch_x < H_ACTIVE) && (w_fetch_x[3:0] == 4'd0);
    w_row        = w_line[8:4];
    w_col        = w_fetch_x[9:4];
    w_tile_addr  = ({7'd0, w_row} << 5) + ({7'd0, w_row} << 3) + {6'd0, w_col};
  end

  // The pending tile is used directly on the load pixel so that rgb stays aligned with the syncs.
  always_comb begin
    w_active = (r_h_cnt < H_ACTIVE) && (r_v_cnt < V_ACTIVE);
    w_load   = (r_h_cnt[3:0] == 4'd0) && (r_h_cnt < H_ACTIVE);
    w_pat    = w_load ? r_pend_pat : r_shift;
    w_fg     = w_load ? r_pend_col : r_fg;
  end

  assign w_unused = ^{vid_data[17:14], glyph_data[17:16]};

  // Pixel-rate enable and the h/v raster counters.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_pix_en <= 1'b0;
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : (r_v_cnt + 10'd1);
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  // Tile fetch FSM: tile word, then glyph row, then park the result in the pending registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state      <= S_IDLE;
      r_vid_addr   <= '0;
      r_glyph_addr <= '0;
      r_line_lo    <= '0;
      r_tile_fg    <= '0;
      r_pend_pat   <= '0;
      r_pend_col   <= '0;
`ifdef TILE_INVERT_EN
      r_tile_inv   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pix_en && w_fetch_slot) begin
            if (w_line < V_ACTIVE) begin
              r_vid_addr <= w_tile_addr;
              r_line_lo  <= w_line[3:0];
              r_state    <= S_ADDR_T;
            end else begin
              r_pend_pat <= '0;
            end
          end
        end
        S_ADDR_T: begin
          r_glyph_addr <= {vid_data[5:0], r_line_lo};
          r_tile_fg    <= vid_data[13:6];
`ifdef TILE_INVERT_EN
          r_tile_inv   <= vid_data[17];
`endif
          r_state      <= S_ADDR_G;
        end
        S_ADDR_G: begin
`ifdef TILE_INVERT_EN
          r_pend_pat <= r_tile_inv ? ~glyph_data[15:0] : glyph_data[15:0];
`else
          r_pend_pat <= glyph_data[15:0];
`endif
          r_pend_col <= r_tile_fg;
          r_state    <= S_CAP;
        end
        S_CAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shift register plus the aligned output stage (rgb, hsync, vsync, blank) updated on pixel enables.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_shift <= '0;
      r_fg    <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_blank <= 1'b1;
      r_rgb   <= BG_COLOUR;
    end else if (r_pix_en) begin
      if (w_load) begin
        r_shift <= {r_pend_pat[14:0], 1'b0};
        r_fg    <= r_pend_col;
      end else if (w_active) begin
        r_shift <= {r_shift[14:0], 1'b0};
      end
      r_hsync <= ~((r_h_cnt >= H_SYNC_S) && (r_h_cnt <= H_SYNC_E));
      r_vsync <= ~((r_v_cnt >= V_SYNC_S) && (r_v_cnt <= V_SYNC_E));
      r_blank <= ~w_active;
      r_rgb   <= (w_active && w_pat[15]) ? w_fg : BG_COLOUR;
    end
  end

  assign vid_addr    = r_vid_addr;
  assign glyph_addr  = r_glyph_addr;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign rgb         = r_rgb;
  assign frame_start = r_pix_en && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

endmodule
